// File: rtl/updown_counter_param_if.sv
// Bus bundle for updown_counter_param: control inputs toward the counter,
// registered count, decoded terminal flags and overflow/underflow pulses back.
interface updown_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             direction;
    logic [WIDTH-1:0] step;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] my_count;
    logic             at_max;
    logic             at_min;
    logic             ovf;
    logic             unf;

    // Side that controls the counter and observes its state.
    modport master (
        output en, direction, step, sat_mode, load, load_value,
        input  my_count, at_max, at_min, ovf, unf
    );

    // The counter itself.
    modport slave (
        input  en, direction, step, sat_mode, load, load_value,
        output my_count, at_max, at_min, ovf, unf
    );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with range 0..MAX_VAL, runtime step size,
// wrap or saturate mode, synchronous load and registered ovf/unf pulses.
// Priority on each edge: rst > load > en > hold.
module updown_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 15,
    parameter int RESET_VAL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    updown_counter_param_if.slave bus
);
    // Reject parameter sets the arithmetic below cannot represent.
    if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1 ||
        RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_params
        $error("updown_counter_param: illegal WIDTH/MAX_VAL/RESET_VAL");
    end

    // One extra bit so count + step and count + modulus never truncate.
    typedef logic [WIDTH:0] wide_t;

    localparam wide_t            MAX_W   = wide_t'(MAX_VAL);
    localparam wide_t            MOD_W   = wide_t'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_N   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_N = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    wide_t cur_w;
    wide_t step_w;
    wide_t load_w;
    wide_t sum_w;

    // Next-state: clamp step and load value, then apply load or one step.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;

        cur_w  = {1'b0, count_q};
        step_w = ({1'b0, bus.step} > MAX_W) ? MAX_W : {1'b0, bus.step};
        load_w = ({1'b0, bus.load_value} > MAX_W) ? MAX_W : {1'b0, bus.load_value};
        sum_w  = cur_w + step_w;

        if (bus.load) begin
            count_d = WIDTH'(load_w);
        end else if (bus.en) begin
            if (!bus.direction) begin
                if (sum_w <= MAX_W) begin
                    count_d = WIDTH'(sum_w);
                end else begin
                    ovf_d   = 1'b1;
                    count_d = bus.sat_mode ? MAX_N : WIDTH'(sum_w - MOD_W);
                end
            end else begin
                if (step_w <= cur_w) begin
                    count_d = WIDTH'(cur_w - step_w);
                end else begin
                    unf_d   = 1'b1;
                    count_d = bus.sat_mode ? '0 : WIDTH'(cur_w + MOD_W - step_w);
                end
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            count_q <= RESET_N;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.my_count = count_q;
    assign bus.at_max   = (count_q == MAX_N);
    assign bus.at_min   = (count_q == '0);
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: a decade instance (WIDTH=4, MAX_VAL=9) and a
// wide instance (WIDTH=8, MAX_VAL=199, RESET_VAL=5). A modulus-arithmetic model
// predicts every cycle; directed vectors add hand-computed literal checks.
module tb_updown_counter_param;
    localparam int A_MAX = 9;
    localparam int A_RV  = 0;
    localparam int B_MAX = 199;
    localparam int B_RV  = 5;

    logic clk = 1'b0;
    logic a_rst;
    logic b_rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(4)) a_if ();
    updown_counter_param_if #(.WIDTH(8)) b_if ();

    updown_counter_param #(.WIDTH(4), .MAX_VAL(A_MAX), .RESET_VAL(A_RV)) dut_a (
        .clk (clk),
        .rst (a_rst),
        .bus (a_if)
    );

    updown_counter_param #(.WIDTH(8), .MAX_VAL(B_MAX), .RESET_VAL(B_RV)) dut_b (
        .clk (clk),
        .rst (b_rst),
        .bus (b_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count lives in 0..mx, modulus mx+1; step clamped to mx.
    function automatic int eff_step(int st, int mx);
        return (st > mx) ? mx : st;
    endfunction

    function automatic int mdl_next(int cur, int mx, int rv, bit r, bit ld, int lv,
                                    bit e, bit d, int st, bit sat);
        int s;
        s = eff_step(st, mx);
        if (r) return rv;
        if (ld) return (lv > mx) ? mx : lv;
        if (!e) return cur;
        if (!d) begin
            if (cur + s <= mx) return cur + s;
            return sat ? mx : (cur + s) % (mx + 1);
        end
        if (s <= cur) return cur - s;
        return sat ? 0 : (cur - s + mx + 1) % (mx + 1);
    endfunction

    function automatic bit mdl_ovf(int cur, int mx, bit r, bit ld, bit e, bit d, int st);
        return !r && !ld && e && !d && (cur + eff_step(st, mx) > mx);
    endfunction

    function automatic bit mdl_unf(int cur, int mx, bit r, bit ld, bit e, bit d, int st);
        return !r && !ld && e && d && (eff_step(st, mx) > cur);
    endfunction

    int a_cnt = 0;
    bit a_ovf = 1'b0;
    bit a_unf = 1'b0;
    bit a_valid = 1'b0;
    int b_cnt = 0;
    bit b_ovf = 1'b0;
    bit b_unf = 1'b0;
    bit b_valid = 1'b0;

    // Model state advances on the same edge as the DUTs.
    always @(posedge clk) begin
        a_cnt <= mdl_next(a_cnt, A_MAX, A_RV, a_rst, a_if.load, int'(a_if.load_value),
                          a_if.en, a_if.direction, int'(a_if.step), a_if.sat_mode);
        a_ovf <= mdl_ovf(a_cnt, A_MAX, a_rst, a_if.load, a_if.en, a_if.direction, int'(a_if.step));
        a_unf <= mdl_unf(a_cnt, A_MAX, a_rst, a_if.load, a_if.en, a_if.direction, int'(a_if.step));
        if (a_rst) a_valid <= 1'b1;
        b_cnt <= mdl_next(b_cnt, B_MAX, B_RV, b_rst, b_if.load, int'(b_if.load_value),
                          b_if.en, b_if.direction, int'(b_if.step), b_if.sat_mode);
        b_ovf <= mdl_ovf(b_cnt, B_MAX, b_rst, b_if.load, b_if.en, b_if.direction, int'(b_if.step));
        b_unf <= mdl_unf(b_cnt, B_MAX, b_rst, b_if.load, b_if.en, b_if.direction, int'(b_if.step));
        if (b_rst) b_valid <= 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (a_valid) begin
            check("A.count",  a_if.my_count, a_cnt);
            check("A.at_max", a_if.at_max,   (a_cnt == A_MAX) ? 1 : 0);
            check("A.at_min", a_if.at_min,   (a_cnt == 0) ? 1 : 0);
            check("A.ovf",    a_if.ovf,      a_ovf);
            check("A.unf",    a_if.unf,      a_unf);
        end
        if (b_valid) begin
            check("B.count",  b_if.my_count, b_cnt);
            check("B.at_max", b_if.at_max,   (b_cnt == B_MAX) ? 1 : 0);
            check("B.at_min", b_if.at_min,   (b_cnt == 0) ? 1 : 0);
            check("B.ovf",    b_if.ovf,      b_ovf);
            check("B.unf",    b_if.unf,      b_unf);
        end
    end

    // Drive one cycle of inputs at a falling edge and return at the next one.
    task automatic a_cyc(input bit r, input bit ld, input int lv, input bit e,
                         input bit d, input int st, input bit sat);
        a_rst             = r;
        a_if.load         = ld;
        a_if.load_value   = 4'(lv);
        a_if.en           = e;
        a_if.direction    = d;
        a_if.step         = 4'(st);
        a_if.sat_mode     = sat;
        @(negedge clk);
    endtask

    task automatic b_cyc(input bit r, input bit ld, input int lv, input bit e,
                         input bit d, input int st, input bit sat);
        b_rst             = r;
        b_if.load         = ld;
        b_if.load_value   = 8'(lv);
        b_if.en           = e;
        b_if.direction    = d;
        b_if.step         = 8'(st);
        b_if.sat_mode     = sat;
        @(negedge clk);
    endtask

    initial begin
        a_rst = 1'b0;
        b_rst = 1'b0;
        a_if.load = 1'b0; a_if.load_value = '0; a_if.en = 1'b0;
        a_if.direction = 1'b0; a_if.step = '0; a_if.sat_mode = 1'b0;
        b_if.load = 1'b0; b_if.load_value = '0; b_if.en = 1'b0;
        b_if.direction = 1'b0; b_if.step = '0; b_if.sat_mode = 1'b0;
        @(negedge clk);

        // Reset state.
        a_cyc(1, 0, 0, 0, 0, 0, 0);
        check("A.rst_count", a_if.my_count, 0);
        check("A.rst_at_min", a_if.at_min, 1);
        check("A.rst_ovf", a_if.ovf, 0);

        // Decade count up with wrap.
        for (int i = 1; i <= 10; i++) begin
            a_cyc(0, 0, 0, 1, 0, 1, 0);
            if (i == 9) begin
                check("A.dec_9", a_if.my_count, 9);
                check("A.dec_at_max", a_if.at_max, 1);
                check("A.dec_no_ovf", a_if.ovf, 0);
            end
        end
        check("A.dec_wrap", a_if.my_count, 0);
        check("A.dec_ovf", a_if.ovf, 1);
        a_cyc(0, 0, 0, 0, 0, 0, 0);
        check("A.idle_ovf_clr", a_if.ovf, 0);

        // Down wrap with step 3 from 2.
        a_cyc(0, 1, 2, 0, 0, 0, 0);
        a_cyc(0, 0, 0, 1, 1, 3, 0);
        check("A.dn_wrap", a_if.my_count, 9);
        check("A.dn_unf", a_if.unf, 1);
        a_cyc(0, 0, 0, 1, 1, 3, 0);
        check("A.dn_6", a_if.my_count, 6);
        check("A.dn_unf_clr", a_if.unf, 0);

        // Saturation up then down, including repeated pulses at the limit.
        a_cyc(0, 1, 8, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            a_cyc(0, 0, 0, 1, 0, 4, 1);
            check("A.sat_up_9", a_if.my_count, 9);
            check("A.sat_up_ovf", a_if.ovf, 1);
        end
        a_cyc(0, 0, 0, 1, 1, 5, 1);
        check("A.sat_dn_4", a_if.my_count, 4);
        a_cyc(0, 0, 0, 1, 1, 5, 1);
        check("A.sat_dn_0", a_if.my_count, 0);
        check("A.sat_dn_unf", a_if.unf, 1);
        a_cyc(0, 0, 0, 1, 1, 5, 1);
        check("A.sat_dn_hold_unf", a_if.unf, 1);

        // Load priority with clamp, then reset over load.
        a_cyc(0, 1, 15, 1, 0, 1, 0);
        check("A.load_clamp", a_if.my_count, 9);
        check("A.load_no_ovf", a_if.ovf, 0);
        a_cyc(1, 1, 5, 1, 0, 1, 0);
        check("A.rst_over_load", a_if.my_count, 0);
        check("A.rst_at_min2", a_if.at_min, 1);

        // Step clamp, zero step, idle hold.
        a_cyc(0, 1, 3, 0, 0, 0, 0);
        a_cyc(0, 0, 0, 1, 0, 15, 0);
        check("A.step_clamp", a_if.my_count, 2);
        check("A.step_clamp_ovf", a_if.ovf, 1);
        a_cyc(0, 0, 0, 1, 0, 0, 0);
        check("A.step0_hold", a_if.my_count, 2);
        check("A.step0_no_ovf", a_if.ovf, 0);
        for (int i = 0; i < 5; i++) a_cyc(0, 0, 0, 0, 0, 0, 0);
        check("A.idle_hold", a_if.my_count, 2);

        // Reset mid-count drops a would-be overflow.
        a_cyc(0, 1, 8, 0, 0, 0, 0);
        a_cyc(1, 0, 0, 1, 0, 3, 0);
        check("A.midrst_count", a_if.my_count, 0);
        check("A.midrst_ovf", a_if.ovf, 0);
        a_cyc(0, 0, 0, 1, 1, 1, 0);
        check("A.dn1_wrap", a_if.my_count, 9);
        check("A.dn1_unf", a_if.unf, 1);

        // Mixed runtime changes of direction, step and mode every cycle.
        for (int i = 0; i < 24; i++) begin
            a_cyc(0, (i % 11) == 10, i, 1, i[0], (i * 7) % 16, i[2]);
        end
        a_cyc(0, 0, 0, 0, 0, 0, 0);

        // Wide instance.
        b_cyc(1, 0, 0, 0, 0, 0, 0);
        check("B.rst_count", b_if.my_count, 5);
        check("B.rst_at_min", b_if.at_min, 0);
        b_cyc(0, 1, 180, 0, 0, 0, 0);
        b_cyc(0, 0, 0, 1, 0, 50, 0);
        check("B.up_wrap", b_if.my_count, 30);
        check("B.up_ovf", b_if.ovf, 1);
        b_cyc(0, 0, 0, 1, 1, 50, 0);
        check("B.dn_wrap", b_if.my_count, 180);
        check("B.dn_unf", b_if.unf, 1);
        b_cyc(0, 1, 250, 0, 0, 0, 0);
        check("B.load_clamp", b_if.my_count, 199);
        check("B.at_max", b_if.at_max, 1);
        b_cyc(0, 0, 0, 1, 0, 255, 0);
        check("B.step_clamp_wrap", b_if.my_count, 198);
        check("B.step_clamp_ovf", b_if.ovf, 1);
        b_cyc(0, 0, 0, 1, 1, 200, 1);
        check("B.sat_dn_0", b_if.my_count, 0);
        check("B.sat_dn_unf", b_if.unf, 1);
        b_cyc(0, 0, 0, 0, 0, 0, 0);
        check("B.idle_unf_clr", b_if.unf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the team's 4-bit up/down counter.
- Generalised in width and modulus, with a runtime-selectable step size and a wrap or saturate mode.
- Adds synchronous load, count enable, registered overflow/underflow pulses and terminal flags.
- Used wherever the design needs a configurable event, position or index counter. Examples: decade counters, menu indices, volume levels.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- MAX_VAL, 15, highest count value; legal range 1 .. 2^WIDTH-1. Count range is 0..MAX_VAL, modulus MAX_VAL+1.
- RESET_VAL, 0, value loaded on reset; must be ≤ MAX_VAL.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  count enable; 1 = apply one step this cycle
- direction  input  1  0 = count up, 1 = count down
- step  input  WIDTH  increment/decrement amount per enabled cycle
- sat_mode  input  1  0 = wrap modulo MAX_VAL+1, 1 = saturate at 0 / MAX_VAL
- load  input  1  synchronous load strobe
- load_value  input  WIDTH  value taken on load
- my_count  output  WIDTH  current count (registered)
- at_max  output  1  1 when my_count == MAX_VAL (decoded from register)
- at_min  output  1  1 when my_count == 0 (decoded from register)
- ovf  output  1  registered one-cycle pulse: an up step crossed MAX_VAL
- unf  output  1  registered one-cycle pulse: a down step crossed below 0

Behaviour:
- Clock and reset:
  - One clock domain; all state updates on rising clk edge.
  - Reset is synchronous and active-high.
- Priority per edge: rst > load > en > hold.
- Reset values:
  - my_count = RESET_VAL; ovf = 0; unf = 0.
  - at_max and at_min are decoded accordingly (RESET_VAL=0 gives at_min=1).
- Load:
  - my_count <= min(load_value, MAX_VAL).
  - ovf = unf = 0 that cycle.
  - en is ignored that cycle.
- Step handling:
  - Effective step s = min(step, MAX_VAL).
  - With en=1 and s=0 the count holds and no flags are raised.
- Arithmetic is done in WIDTH+1 bits so no intermediate truncation occurs.
- Up (direction=0, en=1):
  - If my_count + s ≤ MAX_VAL: next = my_count + s.
  - Else, with sat_mode=0: next = my_count + s − (MAX_VAL+1), ovf=1.
  - Else, with sat_mode=1: next = MAX_VAL, ovf=1.
- Down (direction=1, en=1):
  - If s ≤ my_count: next = my_count − s.
  - Else, with sat_mode=0: next = my_count + (MAX_VAL+1) − s, unf=1.
  - Else, with sat_mode=1: next = 0, unf=1.
- Saturate already at the limit: further up steps at MAX_VAL (or down steps at 0) keep the count and assert ovf (or unf) every enabled cycle.
- Flag timing:
  - ovf/unf are registered and valid in the same cycle the new my_count appears (latency 1 from en).
  - They clear on the next edge unless re-triggered.
- Idle: en=0 and load=0 holds my_count; ovf = unf = 0.
- Runtime changes: direction, step and sat_mode may change every cycle. Each edge uses the values sampled at that edge; there is no pipeline state.
- Reset mid-count: reset overrides a simultaneous load/en; my_count = RESET_VAL on the following cycle and pending flags are cleared.
- Combinational outputs: at_max/at_min are purely combinational from my_count, with no extra latency.

Test Plan:
- Default decade wrap (WIDTH=4, MAX_VAL=9, RESET_VAL=0): rst 1 cycle, then en=1, direction=0, step=1, sat_mode=0 for 10 cycles -> my_count 1..9, then 0. ovf=1 only in the cycle my_count returns to 0. at_max=1 when my_count=9.
- Down wrap with step: load 2, then direction=1, step=3, sat_mode=0, en=1 -> my_count=9 (2+10−3) with unf=1; next edge -> 6, unf=0.
- Saturation: load 8, direction=0, step=4, sat_mode=1, en for 3 cycles -> my_count stays 9, ovf=1 each cycle. Then direction=1, step=5 for 2 cycles -> 4, then 0 with unf=1 on the second.
- Priority and clamping:
  - load=1, load_value=15, en=1, direction=0 -> my_count=9 (clamped), ovf=0.
  - Next cycle rst=1 with load=1 -> my_count=0, at_min=1.
- Step clamp and hold:
  - step=15, direction=0, sat_mode=0 from my_count=3 -> my_count=2 (s=9: 3+9−10), ovf=1.
  - step=0, en=1 -> my_count stays 2, no flags.
  - en=0 for 5 cycles -> my_count stays 2.
- Wider instance (WIDTH=8, MAX_VAL=199): step=50 up from 180 with sat_mode=0 -> my_count=30, ovf=1. Down from 30 with step=50 -> 180, unf=1.
